// File: rtl/uart_tx_encoder.sv
// UART 8N1 transmitter fed by a byte FIFO; serialises LSB-first at CLK_FREQ_HZ/BAUD cycles per bit.
// The line is driven from a register, so o_tx is glitch-free and idles high.
module uart_tx_encoder #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic [1:0]                    o_state
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] TIMER_MAX = TW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            push, pop;

    // Handshake: a byte transfers on any rising edge where i_valid && o_ready;
    // o_ready depends only on the registered level, never on i_valid.
    assign o_ready = (level_q != LW'(FIFO_DEPTH));
    assign push    = i_valid && o_ready;
    assign o_tx    = tx_q;
    assign o_level = level_q;
    assign o_busy  = (state_q != S_IDLE) || (level_q != '0);
    assign o_state = state_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = TIMER_MAX;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_MAX;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_MAX;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    // Chain straight into the next start bit when bytes are waiting.
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        timer_d = TIMER_MAX;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            level_q  <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: tb/tb_uart_tx_encoder.sv
// Bench for uart_tx_encoder at DIV = 10: table-driven frame vectors, hand-written corner sequences,
// and randomized traffic checked by a line-level frame decoder against a queue of pushed bytes.
module tb_uart_tx_encoder;
  localparam int DIV = 10;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic [4:0] o_level;
  logic [1:0] o_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_encoder #(
    .CLK_FREQ_HZ(1000000),
    .BAUD(100000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_tx(o_tx),
    .o_busy(o_busy),
    .o_level(o_level),
    .o_state(o_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard: bytes accepted by the DUT, in order
  logic [7:0] exp_q[$];
  int         start_q[$];

  // reference line decoder: a frame is 0 start, 8 data LSB-first, 1 stop, each exactly DIV cycles
  int         mon_cnt = 0;
  bit         mon_active = 0;
  bit         mon_bad = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp;
  int         mon_frames = 0;
  int         mon_bit;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_active = 0;
      mon_cnt = 0;
      mon_bad = 0;
    end else if (!mon_active) begin
      if (o_tx === 1'b0) begin
        mon_active = 1;
        mon_cnt = 1;
        mon_bad = 0;
        mon_byte = 8'h00;
        start_q.push_back(cyc);
      end
    end else begin
      mon_bit = mon_cnt / DIV;
      if (mon_bit == 0) begin
        if (o_tx !== 1'b0) mon_bad = 1;
      end else if (mon_bit <= 8) begin
        if (mon_cnt % DIV == 0) mon_byte[mon_bit-1] = o_tx;
        else if (o_tx !== mon_byte[mon_bit-1]) mon_bad = 1;
      end else begin
        if (o_tx !== 1'b1) mon_bad = 1;
      end
      mon_cnt++;
      if (mon_cnt == 10 * DIV) begin
        mon_active = 0;
        mon_frames++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected actual=%02h required=no_frame", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_byte !== mon_exp || mon_bad) begin
            errors++;
            $display("FAIL frame_data actual=%02h required=%02h bad_shape=%0d", mon_byte, mon_exp, mon_bad);
          end
        end
      end
    end
  end

  // drivers
  task automatic push_byte(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data = d;
    while (!o_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((o_busy || mon_active) && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", {31'd0, (n < 30000)}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n;
    int acc;
    int maxl;
    int frames_before;
    int gap;

    // line patterns in transmit order: bit 0 = start, bits 1..8 = data LSB-first, bit 9 = stop
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h80, 10'b1_10000000_0};
    vecs[5] = '{8'h01, 10'b1_00000001_0};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, o_tx}, 32'd1);
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_level", {27'd0, o_level}, 32'd0);
    chk("reset_state", {30'd0, o_state}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // single frames from idle, sampled mid-bit
    for (int i = 0; i < 6; i++) begin
      push_byte(vecs[i].data);
      #1;
      chk("latency_tx_high", {31'd0, o_tx}, 32'd1);
      chk("latency_level", {27'd0, o_level}, 32'd1);
      i_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pop_level", {27'd0, o_level}, 32'd0);
      n = 1;
      for (int k = 0; k < 10; k++) begin
        repeat ((k == 0) ? DIV / 2 : DIV) @(posedge clk);
        #1;
        n += (k == 0) ? DIV / 2 : DIV;
        chk($sformatf("line_v%0d_b%0d", i, k), {31'd0, o_tx}, {31'd0, vecs[i].line[k]});
      end
      while (o_busy && n < 300) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("busy_fall_edge", n, 32'd101);
      drain();
    end

    // back-to-back pushes: no idle gap between frames
    start_q.delete();
    push_byte(8'h00);
    #1;
    chk("b2b_level_first", {27'd0, o_level}, 32'd1);
    push_byte(8'hFF);
    #1;
    chk("b2b_level_second", {27'd0, o_level}, 32'd1);
    i_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("b2b_level_before_pop", {27'd0, o_level}, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_level_after_pop", {27'd0, o_level}, 32'd0);
    drain();
    chk("b2b_frames", start_q.size(), 32'd2);
    if (start_q.size() == 2) chk("b2b_spacing", start_q[1] - start_q[0], 32'd100);

    // full FIFO: hold i_valid from idle
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data = 8'($urandom);
      if (o_ready) begin
        acc++;
        exp_q.push_back(i_data);
      end
      @(posedge clk);
    end
    #1;
    i_valid = 1'b0;
    chk("full_accepted", acc, 32'd17);
    chk("full_level", {27'd0, o_level}, 32'd16);
    chk("full_ready", {31'd0, o_ready}, 32'd0);
    n = 40;
    while (!o_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("full_ready_rise_edge", n, 32'd102);
    drain();

    // throttled pushes every third cycle
    maxl = 0;
    for (int b = 1; b <= 8; b++) begin
      push_byte(8'(b));
      #1;
      i_valid = 1'b0;
      if (int'(o_level) > maxl) maxl = int'(o_level);
      repeat (2) begin
        @(posedge clk);
        #1;
        if (int'(o_level) > maxl) maxl = int'(o_level);
      end
    end
    chk("throttle_max_level", {31'd0, (maxl <= 8)}, 32'd1);
    drain();

    // reset during data bit 3 of 0x3C with 4 more bytes queued
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    #1;
    i_valid = 1'b0;
    n = 0;
    while (!(mon_active && mon_cnt == 4 * DIV + 5) && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("midframe_reached", {31'd0, (n < 1000)}, 32'd1);
    frames_before = mon_frames;
    rstn = 1'b0;
    #1;
    chk("midreset_tx", {31'd0, o_tx}, 32'd1);
    chk("midreset_level", {27'd0, o_level}, 32'd0);
    chk("midreset_ready", {31'd0, o_ready}, 32'd1);
    chk("midreset_busy", {31'd0, o_busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rstn = 1'b1;
    push_byte(8'h55);
    #1;
    i_valid = 1'b0;
    drain();
    repeat (300) @(posedge clk);
    #1;
    chk("midreset_frames", mon_frames - frames_before, 32'd1);
    chk("midreset_queue", exp_q.size(), 32'd0);

    // randomized traffic with occasional long pauses
    for (int r = 0; r < 60; r++) begin
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) gap = $urandom_range(50, 250);
      repeat (gap) @(posedge clk);
      push_byte(8'($urandom));
      #1;
      i_valid = 1'b0;
    end
    drain();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_level", {27'd0, o_level}, 32'd0);
    chk("final_tx_idle", {31'd0, o_tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
